// File: rtl/player_pkg.sv
// Shared definitions for the player input path: direction bits, FSM encoding, grid step.
package player_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam int GRID_STEP = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2,
        LOCKED = 2'd3
    } move_state_e;

    // One-hot of the highest-priority pressed direction: up > down > left > right.
    function automatic logic [3:0] prio_sel(input logic [3:0] v);
        logic [3:0] s;
        s = '0;
        if (v[DIR_UP])         s[DIR_UP]    = 1'b1;
        else if (v[DIR_DOWN])  s[DIR_DOWN]  = 1'b1;
        else if (v[DIR_LEFT])  s[DIR_LEFT]  = 1'b1;
        else if (v[DIR_RIGHT]) s[DIR_RIGHT] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit two-flop synchroniser followed by a stability counter; raw edge to
// stable output takes 2+DEBOUNCE_CYCLES cycles, shorter glitches are dropped.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = 16
) (
    input  logic slowClk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the synchronised level agrees with the accepted one restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge slowClk or negedge rst) begin
        if (!rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/player_move_ctrl.sv
// Debounces four direction buttons and issues one registered move strobe per press.
// Auto-repeat while held is built only when PLAYER_AUTOREPEAT_EN is defined.
module player_move_ctrl
    import player_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int HOLD_DELAY      = 250,
    parameter int REPEAT_PERIOD   = 100,
    parameter int CNT_W           = 16
) (
    input  logic        slowClk,
    input  logic        rst,
    input  logic [3:0]  btnsRaw,
    input  logic        playerDisable,
    output logic [3:0]  btns,
    output logic        btnClk2,
    output logic [15:0] moveCount
);

    logic [3:0]  stable;
    logic [3:0]  sel;
    logic        held;
    move_state_e state_q, state_d;
    logic [3:0]  btns_q, btns_d;
    logic        strobe_q, strobe_d;
    logic [15:0] moveCount_q, moveCount_d;

    for (genvar g = 0; g < 4; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .slowClk (slowClk),
            .rst     (rst),
            .raw_i   (btnsRaw[g]),
            .stable_o(stable[g])
        );
    end

    assign sel  = prio_sel(stable);
    assign held = |(stable & btns_q);

`ifdef PLAYER_AUTOREPEAT_EN
    logic [CNT_W-1:0] hold_q, hold_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{HOLD_DELAY, REPEAT_PERIOD};
`endif

    always_comb begin
        state_d  = state_q;
        btns_d   = btns_q;
        strobe_d = 1'b0;
`ifdef PLAYER_AUTOREPEAT_EN
        hold_d   = hold_q + 1'b1;
`endif
        if (playerDisable) begin
            state_d = LOCKED;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stable != 4'b0000) begin
                        btns_d   = sel;
                        strobe_d = 1'b1;
                        state_d  = HELD;
`ifdef PLAYER_AUTOREPEAT_EN
                        hold_d   = '0;
`endif
                    end
                end
                HELD: begin
                    if (!held) begin
                        state_d = IDLE;
`ifdef PLAYER_AUTOREPEAT_EN
                    end else if (hold_q == CNT_W'(HOLD_DELAY - 1)) begin
                        strobe_d = 1'b1;
                        state_d  = REPEAT;
                        hold_d   = '0;
`endif
                    end
                end
`ifdef PLAYER_AUTOREPEAT_EN
                REPEAT: begin
                    if (!held) begin
                        state_d = IDLE;
                    end else if (hold_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                        strobe_d = 1'b1;
                        hold_d   = '0;
                    end
                end
`endif
                LOCKED: begin
                    // Wait for all buttons up so re-enabling never fires a stale press.
                    if (stable == 4'b0000) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        moveCount_d = moveCount_q + {15'd0, strobe_d};
    end

    always_ff @(posedge slowClk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            btns_q      <= 4'b0000;
            strobe_q    <= 1'b0;
            moveCount_q <= 16'd0;
`ifdef PLAYER_AUTOREPEAT_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            btns_q      <= btns_d;
            strobe_q    <= strobe_d;
            moveCount_q <= moveCount_d;
`ifdef PLAYER_AUTOREPEAT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign btns      = btns_q;
    assign btnClk2   = strobe_q;
    assign moveCount = moveCount_q;

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Upstream input stage for the player rectangle logic.
- Conditions the four raw direction buttons: synchronise, debounce, and priority-select one direction.
- Emits a held one-hot direction vector plus a one-cycle move strobe, which drive the player block's btns/btnClk2 inputs.
- Guarantees exactly one grid step per press, and optionally auto-repeats while a button is held.

Parameters:
- DEBOUNCE_CYCLES, 20: consecutive stable slowClk cycles required before a raw level is accepted.
- HOLD_DELAY, 250: cycles a press must be held before the first repeat (auto-repeat only).
- REPEAT_PERIOD, 100: cycles between repeat strobes (auto-repeat only).
- CNT_W, 16: width of all internal cycle counters. Every cycle-count parameter must be below 2^CNT_W.

Ports:
- slowClk  input  1  sole clock, all state rising-edge.
- rst  input  1  asynchronous, active-low reset.
- btnsRaw  input  4  raw pads, asynchronous; [3]=up [2]=down [1]=left [0]=right.
- playerDisable  input  1  suppresses all strobes while high.
- btns  output  4  one-hot registered direction of the last move, same bit order.
- btnClk2  output  1  move strobe, exactly one slowClk cycle wide.
- moveCount  output  16  number of strobes issued; wraps at 65535->0.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchroniser flops, debounced vector, all counters and moveCount clear to 0.
  - btns=4'b0000, btnClk2=0, FSM=IDLE.
  - Reset asserted mid-strobe kills the strobe immediately.
- Synchroniser: two flops per bit. Raw edge to sync output is 2 cycles.
- Debounce, per bit:
  - Counter increments while sync != stable and clears whenever sync == stable.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable takes sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Press-to-stable latency is 2+DEBOUNCE_CYCLES cycles.
- Priority: up > down > left > right. sel is the one-hot of the highest set stable bit.
- FSM states: IDLE, HELD, REPEAT, LOCKED.
  - IDLE: stable!=0 and playerDisable=0 -> btns<=sel, btnClk2=1 next cycle, moveCount+1, go HELD, hold counter cleared.
  - HELD: the stable bit matching btns is released -> IDLE. Another still-held button then fires on the following IDLE cycle.
  - HELD, auto-repeat only: the hold counter reaches HOLD_DELAY-1 -> strobe, go REPEAT.
  - REPEAT: release -> IDLE; every REPEAT_PERIOD cycles -> strobe.
  - Any state, playerDisable=1: no strobe that cycle, go LOCKED.
  - LOCKED: stays until playerDisable=0 and stable==0, then IDLE. No spurious move on re-enable while a button is still held.
- Strobe timing: the strobe is registered. btns is updated in the same cycle btnClk2 rises and holds after the strobe until the next strobe. btns is valid whenever btnClk2=1.
- Simultaneous presses in one debounced cycle: a single strobe, highest-priority direction only.
- Minimum spacing between strobes is 2 cycles (strobe, then at least one IDLE/HELD cycle).

Optional Feature:
- Macro: PLAYER_AUTOREPEAT_EN.
- Defined: HELD/REPEAT auto-repeat as described, using HOLD_DELAY and REPEAT_PERIOD.
- Undefined: REPEAT state and hold counter are not built. HELD waits only for release, one strobe per press. HOLD_DELAY and REPEAT_PERIOD are ignored.

Decomposition:
- Shared package player_pkg holds:
  - Direction bit indices: DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0.
  - FSM state encoding: IDLE=0, HELD=1, REPEAT=2, LOCKED=3.
  - GRID_STEP=12, for downstream users.
- One sub-module, btn_debounce: a single-bit synchroniser plus debounce counter, instantiated 4 times. Parameters DEBOUNCE_CYCLES and CNT_W.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, HOLD_DELAY=10, REPEAT_PERIOD=5.
1. Reset release, no input -> btns=0, btnClk2=0, moveCount=0 for 100 cycles.
2. Hold btnsRaw=4'b0001 for 20 cycles:
   - exactly one btnClk2 pulse, 2+4+1 cycles after the press;
   - btns=4'b0001; moveCount=1;
   - without the macro, no further pulses.
3. 3-cycle glitch on up -> no strobe, moveCount unchanged.
4. btnsRaw=4'b1011 in the same cycle -> one strobe, btns=4'b1000.
5. Macro defined, hold left for 40 cycles after stable -> strobes at t0, t0+10, t0+15, t0+20, ...; moveCount=7.
6. playerDisable=1 while holding down, then drop playerDisable with down still held -> no strobe. Release and press again -> one strobe, btns=4'b0100.
